reg_bus_arbiter: RTL and testbench

//  Shares the single NetFPGA register bus (reg_req/reg_ack/reg_addr/reg_wr_data/reg_rd_data) among
//  NUM_REQ register masters (switch reg FIFO drain path, host CPCI path, ...). Each access is arbitrated

---
 rtl/reg_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Purpose : round-robin arbiter sharing one NetFPGA register bus among NUM_REQ masters; optional REG_ARB_STATS_EN adds access/timeout statistics.
// Latency : req_vld -> reg_req 1 cycle; reg_ack -> req_ack 1 cycle; a stalled access is aborted after TIMEOUT bus cycles.
// Backpress: requesters hold req_vld until their req_ack pulse; one access in flight, at most one grant every 3 cycles.
module reg_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_rd_wr_L,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_rd_data,
    output logic                      req_err,
    output logic                      reg_req,
    output logic                      reg_rd_wr_L,
    output logic [ADDR_W-1:0]         reg_addr,
    output logic [DATA_W-1:0]         reg_wr_data,
    input  logic                      reg_ack,
    input  logic [DATA_W-1:0]         reg_rd_data
`ifdef REG_ARB_STATS_EN
    ,
    output logic [31:0]               stat_access_cnt,
    output logic [15:0]               stat_timeout_cnt,
    output logic [ADDR_W-1:0]         stat_last_to_addr
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0]  PTR_RST     = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_PATTERN = DATA_W'(32'hDEAD_DEAD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   grant, grant_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               reg_req_nxt;
    logic               reg_rd_wr_L_nxt;
    logic [ADDR_W-1:0]  reg_addr_nxt;
    logic [DATA_W-1:0]  reg_wr_data_nxt;
    logic [NUM_REQ-1:0] req_ack_nxt;
    logic [DATA_W-1:0]  req_rd_data_nxt;
    logic               req_err_nxt;

    logic               arb_hit;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic               sel_rd_wr_L;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wr_data;

    // Round-robin pick: first valid requester after the last winner, then mux its request fields.
    always_comb begin
        arb_hit     = 1'b0;
        arb_idx     = '0;
        scan_idx    = '0;
        sel_rd_wr_L = 1'b0;
        sel_addr    = '0;
        sel_wr_data = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!arb_hit && req_vld[i] && (PTR_W'(i) == scan_idx)) begin
                    arb_hit = 1'b1;
                    arb_idx = scan_idx;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == arb_idx) begin
                sel_rd_wr_L = req_rd_wr_L[i];
                sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
                sel_wr_data = req_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Access FSM: next state and next values of every registered output.
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        grant_nxt       = grant;
        cnt_nxt         = cnt;
        reg_req_nxt     = reg_req;
        reg_rd_wr_L_nxt = reg_rd_wr_L;
        reg_addr_nxt    = reg_addr;
        reg_wr_data_nxt = reg_wr_data;
        req_ack_nxt     = req_ack;
        req_rd_data_nxt = req_rd_data;
        req_err_nxt     = req_err;
        case (state)
            ST_IDLE: begin
                if (arb_hit) begin
                    grant_nxt       = arb_idx;
                    reg_req_nxt     = 1'b1;
                    reg_rd_wr_L_nxt = sel_rd_wr_L;
                    reg_addr_nxt    = sel_addr;
                    reg_wr_data_nxt = sel_wr_data;
                    cnt_nxt         = '0;
                    state_nxt       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (reg_ack || (cnt == CNT_LAST)) begin
                    // A real ack on the terminal cycle still counts as success.
                    if (reg_ack) begin
                        req_rd_data_nxt = reg_rd_wr_L ? reg_rd_data : '0;
                        req_err_nxt     = 1'b0;
                    end else begin
                        req_rd_data_nxt = ERR_PATTERN;
                        req_err_nxt     = 1'b1;
                    end
                    reg_req_nxt = 1'b0;
                    ptr_nxt     = grant;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ack_nxt[i] = (PTR_W'(i) == grant);
                    end
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                req_ack_nxt     = '0;
                req_rd_data_nxt = '0;
                req_err_nxt     = 1'b0;
                state_nxt       = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access without acking it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= PTR_RST;
            grant       <= '0;
            cnt         <= '0;
            reg_req     <= 1'b0;
            reg_rd_wr_L <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            req_ack     <= '0;
            req_rd_data <= '0;
            req_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            cnt         <= cnt_nxt;
            reg_req     <= reg_req_nxt;
            reg_rd_wr_L <= reg_rd_wr_L_nxt;
            reg_addr    <= reg_addr_nxt;
            reg_wr_data <= reg_wr_data_nxt;
            req_ack     <= req_ack_nxt;
            req_rd_data <= req_rd_data_nxt;
            req_err     <= req_err_nxt;
        end
    end

`ifdef REG_ARB_STATS_EN
    logic stat_done_evt;
    logic stat_to_evt;
    assign stat_done_evt = (state == ST_BUSY) && (reg_ack || (cnt == CNT_LAST));
    assign stat_to_evt   = (state == ST_BUSY) && !reg_ack && (cnt == CNT_LAST);

    // Saturating access/timeout counters plus the address of the latest timed-out access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_access_cnt   <= '0;
            stat_timeout_cnt  <= '0;
            stat_last_to_addr <= '0;
        end else begin
            if (stat_done_evt && (stat_access_cnt != '1)) begin
                stat_access_cnt <= stat_access_cnt + 32'd1;
            end
            if (stat_to_evt) begin
                stat_last_to_addr <= reg_addr;
                if (stat_timeout_cnt != '1) begin
                    stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Purpose : directed bench for reg_bus_arbiter (2 requesters, TIMEOUT=8).
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpress: requesters model hold-until-ack and drop after the ack pulse.
module tb_reg_bus_arbiter;

    localparam int NR = 2;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req_vld = '0;
    logic [NR-1:0]   req_rd_wr_L = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wr_data = '0;
    logic [NR-1:0]   req_ack;
    logic [DW-1:0]   req_rd_data;
    logic            req_err;
    logic            reg_req;
    logic            reg_rd_wr_L;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wr_data;
    logic            reg_ack = 1'b0;
    logic [DW-1:0]   reg_rd_data = '0;
`ifdef REG_ARB_STATS_EN
    logic [31:0]     stat_access_cnt;
    logic [15:0]     stat_timeout_cnt;
    logic [AW-1:0]   stat_last_to_addr;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [AW-1:0] ADDR0 = 27'h0400010;
    localparam logic [AW-1:0] ADDR1 = 27'h0400020;
    localparam logic [DW-1:0] WD0   = 32'hAAAA_0000;
    localparam logic [DW-1:0] WD1   = 32'h5555_1111;

    reg_bus_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_vld     (req_vld),
        .req_rd_wr_L (req_rd_wr_L),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_ack     (req_ack),
        .req_rd_data (req_rd_data),
        .req_err     (req_err),
        .reg_req     (reg_req),
        .reg_rd_wr_L (reg_rd_wr_L),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_ack     (reg_ack),
        .reg_rd_data (reg_rd_data)
`ifdef REG_ARB_STATS_EN
        ,
        .stat_access_cnt   (stat_access_cnt),
        .stat_timeout_cnt  (stat_timeout_cnt),
        .stat_last_to_addr (stat_last_to_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b0;
        req_vld = '0;
        reg_ack = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int g;
        req_addr    = {ADDR1, ADDR0};
        req_wr_data = {WD1, WD0};

        // 1: reset held with both requesting
        reset   = 1'b0;
        req_vld = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_reg_req", 32'(reg_req), 32'd0);
            chk("rst_req_ack", 32'(req_ack), 32'd0);
            chk("rst_rd_data", req_rd_data, 32'd0);
        end
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        req_vld = 2'b00;
        reset   = 1'b1;
        tick();

        // 2: single read from requester 0
        req_rd_wr_L = 2'b11;
        req_vld     = 2'b01;
        tick();
        chk("rd_reg_req", 32'(reg_req), 32'd1);
        chk("rd_reg_addr", 32'(reg_addr), 32'h0400010);
        chk("rd_dir", 32'(reg_rd_wr_L), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rd_wait_req", 32'(reg_req), 32'd1);
            chk("rd_wait_ack", 32'(req_ack), 32'd0);
        end
        reg_ack     = 1'b1;
        reg_rd_data = 32'h1234_5678;
        tick();
        chk("rd_ack", 32'(req_ack), 32'h1);
        chk("rd_data", req_rd_data, 32'h1234_5678);
        chk("rd_err", 32'(req_err), 32'd0);
        chk("rd_req_drop", 32'(reg_req), 32'd0);
        reg_ack     = 1'b0;
        reg_rd_data = '0;
        req_vld     = 2'b00;
        tick();
        chk("rd_ack_clr", 32'(req_ack), 32'd0);
        chk("rd_data_clr", req_rd_data, 32'd0);

        // 3: fairness with both requesters writing continuously
        do_reset(2);
        req_rd_wr_L = 2'b00;
        req_vld     = 2'b11;
        reg_rd_data = 32'hFFFF_FFFF;
        g = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("rr_reg_req", 32'(reg_req), 32'd1);
            chk("rr_addr", 32'(reg_addr), 32'((g == 0) ? ADDR0 : ADDR1));
            chk("rr_wdata", reg_wr_data, (g == 0) ? WD0 : WD1);
            chk("rr_dir", 32'(reg_rd_wr_L), 32'd0);
            reg_ack = 1'b1;
            tick();
            chk("rr_ack", 32'(req_ack), (g == 0) ? 32'h1 : 32'h2);
            chk("rr_wr_rdata", req_rd_data, 32'd0);
            reg_ack = 1'b0;
            tick();
            g = 1 - g;
        end
        req_vld     = 2'b00;
        reg_rd_data = '0;

        // 4: timeout on requester 1, then a late ack
        do_reset(2);
        req_rd_wr_L = 2'b11;
        req_vld     = 2'b10;
        tick();
        hi = 0;
        while (reg_req && hi < 20) begin
            hi++;
            tick();
        end
        chk("to_req_cycles", 32'(hi), 32'd8);
        chk("to_ack", 32'(req_ack), 32'h2);
        chk("to_data", req_rd_data, 32'hDEAD_DEAD);
        chk("to_err", 32'(req_err), 32'd1);
        req_vld = 2'b00;
        tick();
        reg_ack     = 1'b1;
        reg_rd_data = 32'h0BAD_0BAD;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("late_reg_req", 32'(reg_req), 32'd0);
            chk("late_req_ack", 32'(req_ack), 32'd0);
            chk("late_err", 32'(req_err), 32'd0);
            chk("late_data", req_rd_data, 32'd0);
        end
        reg_ack     = 1'b0;
        reg_rd_data = '0;

        // 5: ack on the terminal BUSY cycle wins over timeout
        do_reset(2);
        req_rd_wr_L = 2'b11;
        req_vld     = 2'b01;
        tick();
        repeat (7) tick();
        chk("term_still_busy", 32'(reg_req), 32'd1);
        chk("term_no_ack_yet", 32'(req_ack), 32'd0);
        reg_ack     = 1'b1;
        reg_rd_data = 32'hCAFE_F00D;
        tick();
        chk("term_ack", 32'(req_ack), 32'h1);
        chk("term_err", 32'(req_err), 32'd0);
        chk("term_data", req_rd_data, 32'hCAFE_F00D);
        reg_ack     = 1'b0;
        reg_rd_data = '0;
        req_vld     = 2'b00;
        tick();

        // 6: reset during BUSY abandons the access; requester 0 wins afterwards
        req_vld = 2'b10;
        tick();
        chk("mid_busy", 32'(reg_req), 32'd1);
        chk("mid_addr1", 32'(reg_addr), 32'h0400020);
        reset = 1'b0;
        tick();
        chk("mid_rst_req", 32'(reg_req), 32'd0);
        chk("mid_rst_ack", 32'(req_ack), 32'd0);
        reset   = 1'b1;
        req_vld = 2'b11;
        tick();
        chk("mid_regrant_req", 32'(reg_req), 32'd1);
        chk("mid_regrant_addr", 32'(reg_addr), 32'h0400010);
        chk("mid_regrant_noack", 32'(req_ack), 32'd0);
        reg_ack     = 1'b1;
        reg_rd_data = 32'h0000_00A5;
        tick();
        chk("mid_ack", 32'(req_ack), 32'h1);
        chk("mid_data", req_rd_data, 32'h0000_00A5);
        reg_ack = 1'b0;
        req_vld = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
